// File: rtl/shared_reg_pkg.sv
// Shared types, defaults and the round-robin winner search for shared_reg_arbiter.
package shared_reg_pkg;

    localparam int unsigned MaxReq      = 8;
    localparam int unsigned DefNumReq   = 4;
    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefMaxBurst = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    // First requester found scanning upward from last+1, wrapping modulo num_req.
    // Returns last unchanged when nobody is requesting.
    function automatic logic [2:0] rr_next(input logic [MaxReq-1:0] req,
                                           input logic [2:0]        last,
                                           input int unsigned       num_req);
        logic [2:0]  win;
        logic        found;
        int unsigned idx;
        win   = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MaxReq; i++) begin
            if (!found && i <= num_req) begin
                idx = (32'(last) + i) % num_req;
                if (req[idx]) begin
                    win   = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/shared_reg_word.sv
// DATA_W-bit falling-edge storage word with synchronous active-high clear and load enable.
module shared_reg_word #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] word_q;

    always_ff @(negedge clk) begin
        if (clr) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one register among NUM_REQ requesters, with burst limit and gap.
// Define SHARED_REG_PARITY_EN to add the q_par output (XOR of q).
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DefNumReq,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned MAX_BURST = DefMaxBurst
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          wr_en,
    input  logic [NUM_REQ*DATA_W-1:0]   wr_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    output logic [DATA_W-1:0]           q
`ifdef SHARED_REG_PARITY_EN
    ,
    output logic                        q_par
`endif
);

    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BurstMax = BW'(MAX_BURST);

    arb_state_t        state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     last_q, last_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;

    logic [MaxReq-1:0]  req_ext;
    logic [OW-1:0]      win;
    logic [NUM_REQ-1:0] owner_oh;
    logic               others;
    logic               wr_sel;
    logic [DATA_W-1:0]  wr_word;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
    end

    assign win = OW'(rr_next(req_ext, 3'(last_q), NUM_REQ));

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    assign others = |(req & ~owner_oh);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                if (|req) begin
                    state_d = GRANT;
                    owner_d = win;
                    last_d  = win;
                    burst_d = BW'(1);
                end
            end
            GRANT: begin
                if (!req[owner_q] || (burst_q == BurstMax && others)) begin
                    state_d = GAP;
                end else if (burst_q != BurstMax) begin
                    burst_d = burst_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is registered: derived from the state and owner being loaded this edge.
    always_comb begin
        gnt_d = '0;
        if (state_d == GRANT) begin
            gnt_d[owner_d] = 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            burst_q <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            gnt_q   <= gnt_d;
        end
    end

    assign wr_sel = (state_q == GRANT) && wr_en[owner_q];

    always_comb begin
        wr_word = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                wr_word = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    shared_reg_word #(
        .DATA_W(DATA_W)
    ) u_word (
        .clk (clk),
        .clr (rst),
        .load(wr_sel),
        .d   (wr_word),
        .q   (q)
    );

`ifdef SHARED_REG_PARITY_EN
    assign q_par = ^q;
`endif

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus random traffic vs a model.
module tb_shared_reg_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     wr_en;
    logic [NR*DW-1:0]  wr_data;
    logic [NR-1:0]     gnt;
    logic [1:0]        owner;
    logic              busy;
    logic [DW-1:0]     q;
`ifdef SHARED_REG_PARITY_EN
    logic              q_par;
`endif

    always #5 clk = ~clk;

    shared_reg_arbiter #(
        .NUM_REQ  (NR),
        .DATA_W   (DW),
        .MAX_BURST(MB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .gnt    (gnt),
        .owner  (owner),
        .busy   (busy),
        .q      (q)
`ifdef SHARED_REG_PARITY_EN
        ,
        .q_par  (q_par)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the register, for how long, and whether a gap is pending.
    bit          m_held;
    bit          m_gap;
    int          m_owner;
    int          m_last;
    int          m_run;
    logic [7:0]  m_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int others;
        if (rst) begin
            m_held  = 0;
            m_gap   = 0;
            m_owner = 0;
            m_last  = NR - 1;
            m_run   = 0;
            m_q     = '0;
        end else if (m_held) begin
            if (wr_en[m_owner]) m_q = wr_data[m_owner*DW +: DW];
            others = 0;
            for (int i = 0; i < NR; i++) if (i != m_owner && req[i]) others = 1;
            if (!req[m_owner] || (m_run >= MB && others != 0)) begin
                m_held = 0;
                m_gap  = 1;
            end else if (m_run < MB) begin
                m_run++;
            end
        end else begin
            m_gap = 0;
            for (int k = 1; k <= NR; k++) begin
                if (!m_held && req[(m_last + k) % NR]) begin
                    m_owner = (m_last + k) % NR;
                    m_last  = m_owner;
                    m_held  = 1;
                    m_run   = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NR-1:0] exp_gnt;
        exp_gnt = '0;
        if (m_held) exp_gnt[m_owner] = 1'b1;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("owner", 32'(owner), 32'(m_owner));
        check("busy", 32'(busy), 32'(m_held || m_gap));
        check("q", 32'(q), 32'(m_q));
`ifdef SHARED_REG_PARITY_EN
        check("q_par", 32'(q_par), 32'(^m_q));
`endif
    endtask

    task automatic cycle();
        @(negedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    logic [NR-1:0] rr_table [12];

    initial begin
        rr_table = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                     4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        rst     = 1'b1;
        req     = 4'b1111;
        wr_en   = '0;
        wr_data = '0;
        m_held = 0; m_gap = 0; m_owner = 0; m_last = NR - 1; m_run = 0; m_q = '0;

        // Reset held for two edges with everyone requesting
        cycle();
        cycle();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_q", 32'(q), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);

        // Single write from requester 2
        rst     = 1'b0;
        req     = 4'b0100;
        wr_en   = 4'b0100;
        wr_data = '0;
        wr_data[2*DW +: DW] = 8'hA5;
        cycle();
        check("sw_gnt", 32'(gnt), 32'b0100);
        check("sw_q_before", 32'(q), 32'h0);
        cycle();
        check("sw_q", 32'(q), 32'hA5);
`ifdef SHARED_REG_PARITY_EN
        check("sw_par", 32'(q_par), 32'h0);
`endif
        req   = '0;
        wr_en = '0;
        cycle();
        cycle();

        // Round-robin with everyone requesting
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check($sformatf("rr_%0d", i), 32'(gnt), 32'(rr_table[i]));
        end

        // Lone requester keeps the grant past the burst limit
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("lone_%0d", i), 32'(gnt), 32'b0010);
        end

        // Non-owner write ignored, owner write lands
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req = 4'b0001;
        cycle();
        wr_en   = 4'b1000;
        wr_data = '0;
        wr_data[3*DW +: DW] = 8'h3C;
        wr_data[0 +: DW]    = 8'h77;
        cycle();
        check("nonown_q", 32'(q), 32'h0);
        wr_en            = 4'b0001;
        wr_data[0 +: DW] = 8'h11;
        cycle();
        check("own_q", 32'(q), 32'h11);

        // Reset during a grant discards the concurrent write
        rst              = 1'b1;
        wr_data[0 +: DW] = 8'hFF;
        cycle();
        check("rmid_q", 32'(q), 32'h0);
        check("rmid_gnt", 32'(gnt), 32'h0);
        rst   = 1'b0;
        wr_en = '0;
        req   = 4'b1111;
        cycle();
        check("rmid_first", 32'(gnt), 32'b0001);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            req     = NR'($urandom);
            wr_en   = NR'($urandom);
            wr_data = {$urandom};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
